// File: rtl/hex_event_pkg.sv
// Shared hex raster event layout: field positions, word struct, reader FSM states.
// The event writer imports the same package so both directions agree on one layout.
package hex_event_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned WORD_W      = 64;
   localparam int unsigned EVENT_BYTES = 8;
   localparam int unsigned EVENT_SHIFT = $clog2(EVENT_BYTES);

   localparam int unsigned Q_MSB     = 63;
   localparam int unsigned Q_LSB     = 48;
   localparam int unsigned R_MSB     = 47;
   localparam int unsigned R_LSB     = 32;
   localparam int unsigned DEPTH_MSB = 31;
   localparam int unsigned DEPTH_LSB = 24;
   localparam int unsigned MAT_MSB   = 23;
   localparam int unsigned MAT_LSB   = 16;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic [7:0]  depth;
      logic [7:0]  material;
      logic [15:0] rsvd;
   } hex_event_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      FIN
   } state_t;

   // Byte address of event 'index' in a buffer; wraps modulo 2^32.
   function automatic logic [ADDR_W-1:0] event_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] index);
      return base + (index << EVENT_SHIFT);
   endfunction

endpackage

// File: rtl/hex_event_reader_if.sv
// Read-port and event-stream signals of the hex event reader.
// master: the reader (issues reads, sources events); slave: memory and consumer side.
interface hex_event_reader_if;
   import hex_event_pkg::*;

   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_req;
   logic               mem_ready;
   logic               mem_rvalid;
   logic [WORD_W-1:0]  mem_rdata;

   logic               ev_valid;
   logic               ev_ready;
   logic signed [15:0] ev_q;
   logic signed [15:0] ev_r;
   logic [7:0]         ev_depth;
   logic [7:0]         ev_material;

   modport master (
      output mem_addr, mem_req,
      input  mem_ready, mem_rvalid, mem_rdata,
      output ev_valid, ev_q, ev_r, ev_depth, ev_material,
      input  ev_ready
   );

   modport slave (
      input  mem_addr, mem_req,
      output mem_ready, mem_rvalid, mem_rdata,
      input  ev_valid, ev_q, ev_r, ev_depth, ev_material,
      output ev_ready
   );

endinterface

// File: rtl/hex_event_fifo.sv
// Synchronous show-ahead FIFO: rdata always shows the head entry while not empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module hex_event_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/hex_event_reader.sv
// Hex event reader: on frame_start fetches event_count 64-bit events from
// buffer_base + 8*i through an in-order pipelined read port, buffers them and
// presents decoded q/r/depth/material fields as a valid/ready stream.
module hex_event_reader
   import hex_event_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_start,
   input  logic [ADDR_W-1:0]      buffer_base,
   input  logic [CNT_W-1:0]       event_count,
   hex_event_reader_if.master     bus,
   output logic                   busy,
   output logic                   done
);
   localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] base_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  received;
   logic [CNT_W-1:0]  consumed;
   logic [CNT_W-1:0]  received_nx;
   logic [CNT_W-1:0]  consumed_nx;
   logic [CNT_W-1:0]  outstanding;
   logic              accept;
   logic              req;
   logic              req_fire;
   logic              credit_ok;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FC_W-1:0]   fifo_count;
   logic [WORD_W-1:0] fifo_rdata;
   hex_event_t        head;
   logic              unused_rsvd;

   // Requests may only be issued while every in-flight response has a FIFO slot.
   assign outstanding = issued - received;
   assign credit_ok   = ({1'b0, outstanding} + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(FIFO_DEPTH);

   assign push        = bus.mem_rvalid && (state != IDLE);
   assign pop         = !fifo_empty && bus.ev_ready;
   assign req_fire    = req && bus.mem_ready;
   assign received_nx = received + CNT_W'(push);
   assign consumed_nx = consumed + CNT_W'(pop);

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state and request decode. A zero-length frame passes through DRAIN
   // (exit condition already true) so busy is seen for one cycle before done.
   // DRAIN exit uses the post-edge counts so done follows the last pop by one cycle.
   always_comb begin
      state_nx = state;
      req      = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               accept   = 1'b1;
               state_nx = (event_count == '0) ? DRAIN : FETCH;
            end
         end
         FETCH: begin
            req = (issued < count_r) && credit_ok;
            if (req && bus.mem_ready && (issued + CNT_W'(1) == count_r))
               state_nx = DRAIN;
         end
         DRAIN: begin
            if ((received_nx == count_r) && (consumed_nx == count_r))
               state_nx = FIN;
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Frame parameters and issued/received/consumed counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_r   <= '0;
         count_r  <= '0;
         issued   <= '0;
         received <= '0;
         consumed <= '0;
      end else if (accept) begin
         base_r   <= buffer_base;
         count_r  <= event_count;
         issued   <= '0;
         received <= '0;
         consumed <= '0;
      end else begin
         if (req_fire) issued <= issued + CNT_W'(1);
         received <= received_nx;
         consumed <= consumed_nx;
      end
   end

   hex_event_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (bus.mem_rdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Decode the head word; fields read as zero while the FIFO is empty.
   always_comb begin
      head = '0;
      if (!fifo_empty) begin
         head.q        = fifo_rdata[Q_MSB:Q_LSB];
         head.r        = fifo_rdata[R_MSB:R_LSB];
         head.depth    = fifo_rdata[DEPTH_MSB:DEPTH_LSB];
         head.material = fifo_rdata[MAT_MSB:MAT_LSB];
         head.rsvd     = fifo_rdata[MAT_LSB-1:0];
      end
   end

   assign unused_rsvd     = ^head.rsvd;

   assign bus.ev_valid    = !fifo_empty;
   assign bus.ev_q        = head.q;
   assign bus.ev_r        = head.r;
   assign bus.ev_depth    = head.depth;
   assign bus.ev_material = head.material;

   assign bus.mem_req     = req;
   assign bus.mem_addr    = req ? event_addr(base_r, 32'(issued)) : '0;

   assign busy = (state == FETCH) || (state == DRAIN);
   assign done = (state == FIN);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && fifo_full && !pop));

   a_no_idle_rvalid: assert property (@(posedge clk) disable iff (reset)
      !(bus.mem_rvalid && (state == IDLE)));

endmodule

// File: tb/tb_hex_event_reader.sv
module tb_hex_event_reader;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned CNT_W      = 16;

   logic             clk;
   logic             reset;
   logic             frame_start;
   logic [31:0]      buffer_base;
   logic [CNT_W-1:0] event_count;
   logic             busy;
   logic             done;

   hex_event_reader_if bus();

   hex_event_reader #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .buffer_base (buffer_base),
      .event_count (event_count),
      .bus         (bus),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          due;
      logic [63:0] data;
   } resp_t;

   resp_t       pend[$];
   logic [31:0] addr_log[$];
   logic [47:0] ev_log[$];

   int n_checks, n_fail;
   int cyc, lat, fs_cyc, rp_idx;
   int done_cnt, done_cyc, busy_cnt, req_cnt, first_req_cyc, first_valid_cyc;
   int rvalid_cnt, stall_cnt, stall_viol, hold_viol;
   bit ready_toggle, ev_ready_en, fs_req, prev_stall, prev_hold;
   logic [3:0]  rpat;
   logic [31:0] prev_addr;
   logic [47:0] prev_fields;

   // Memory contents: one fixed word at 0x1000, otherwise derived from the address.
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1000) return 64'h0005_FFFD_7F03_0000;
      return {a[18:3], ~a[18:3], a[10:3], a[10:3] ^ 8'hA5, 16'hBEEF};
   endfunction

   task automatic clear_logs();
      addr_log.delete();
      ev_log.delete();
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; req_cnt = 0;
      first_req_cyc = -1; first_valid_cyc = -1;
      rvalid_cnt = 0; stall_cnt = 0; stall_viol = 0; hold_viol = 0;
   endtask

   task automatic start_frame(input logic [31:0] base, input logic [CNT_W-1:0] n);
      buffer_base = base;
      event_count = n;
      fs_req = 1'b1;
   endtask

   // One clock cycle of memory model, consumer and monitors, all at the falling edge.
   task automatic cycle();
      logic [47:0] f;
      resp_t r;
      @(negedge clk);
      f = {bus.ev_q, bus.ev_r, bus.ev_depth, bus.ev_material};
      if (prev_stall && (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr)) stall_viol++;
      if (prev_hold && (bus.ev_valid !== 1'b1 || f !== prev_fields)) hold_viol++;
      bus.mem_ready = ready_toggle ? rpat[rp_idx] : 1'b1;
      rp_idx = (rp_idx + 1) % 4;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = r.data;
         rvalid_cnt++;
      end else begin
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = {$urandom, $urandom};
      end
      if (bus.mem_req === 1'b1) begin
         req_cnt++;
         if (first_req_cyc < 0) first_req_cyc = cyc;
         if (bus.mem_ready) begin
            addr_log.push_back(bus.mem_addr);
            pend.push_back('{due: cyc + lat, data: mem_word(bus.mem_addr)});
         end else begin
            stall_cnt++;
         end
      end
      bus.ev_ready = ev_ready_en;
      if (bus.ev_valid === 1'b1) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (ev_ready_en) ev_log.push_back(f);
      end
      prev_stall  = (bus.mem_req === 1'b1) && !bus.mem_ready;
      prev_addr   = bus.mem_addr;
      prev_hold   = (bus.ev_valid === 1'b1) && !ev_ready_en;
      prev_fields = f;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy === 1'b1) busy_cnt++;
      frame_start = fs_req;
      if (fs_req) fs_cyc = cyc;
      fs_req = 1'b0;
      cyc++;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
      n_checks++; if (bus.ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %b want 0", bus.ev_valid); end
      n_checks++; if ({bus.ev_q, bus.ev_r, bus.ev_depth, bus.ev_material} !== 48'h0) begin n_fail++; $display("FAIL reset_ev_fields: got %h want 0", {bus.ev_q, bus.ev_r, bus.ev_depth, bus.ev_material}); end
      n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
      cycle(); cycle();
      reset = 1'b0;
      cycle();
      n_checks++; if ({busy, done, bus.mem_req} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle: got %b want 000", {busy, done, bus.mem_req}); end
   endtask

   task automatic test_single();
      logic [47:0] e;
      clear_logs();
      lat = 1; ev_ready_en = 1'b1;
      start_frame(32'h0000_1000, 16'd1);
      for (int i = 0; i < 30 && done_cnt == 0; i++) cycle();
      cycle(); cycle();
      e = (ev_log.size() > 0) ? ev_log[0] : 48'h0;
      n_checks++; if (addr_log.size() !== 1) begin n_fail++; $display("FAIL single_req_count: got %0d want 1", addr_log.size()); end
      n_checks++; if (first_req_cyc !== fs_cyc + 1) begin n_fail++; $display("FAIL single_req_time: got %0d want %0d", first_req_cyc, fs_cyc + 1); end
      n_checks++; if ((addr_log.size() > 0 ? addr_log[0] : 32'hX) !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr: got %h want 00001000", addr_log.size() > 0 ? addr_log[0] : 32'hX); end
      n_checks++; if (first_valid_cyc !== fs_cyc + 3) begin n_fail++; $display("FAIL single_valid_time: got %0d want %0d", first_valid_cyc, fs_cyc + 3); end
      n_checks++; if (e[47:32] !== 16'h0005) begin n_fail++; $display("FAIL single_q: got %h want 0005", e[47:32]); end
      n_checks++; if (e[31:16] !== 16'hFFFD) begin n_fail++; $display("FAIL single_r: got %h want fffd", e[31:16]); end
      n_checks++; if (e[15:8] !== 8'h7F) begin n_fail++; $display("FAIL single_depth: got %h want 7f", e[15:8]); end
      n_checks++; if (e[7:0] !== 8'h03) begin n_fail++; $display("FAIL single_material: got %h want 03", e[7:0]); end
      n_checks++; if (done_cyc !== fs_cyc + 4) begin n_fail++; $display("FAIL single_done_time: got %0d want %0d", done_cyc, fs_cyc + 4); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_zero_count();
      clear_logs();
      start_frame(32'h0000_7000, 16'd0);
      for (int i = 0; i < 10 && done_cnt == 0; i++) cycle();
      cycle(); cycle();
      n_checks++; if (req_cnt !== 0) begin n_fail++; $display("FAIL zero_no_req: got %0d want 0", req_cnt); end
      n_checks++; if (done_cyc !== fs_cyc + 2) begin n_fail++; $display("FAIL zero_done_time: got %0d want %0d", done_cyc, fs_cyc + 2); end
      n_checks++; if (busy_cnt !== 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_backpressure();
      logic [31:0] a;
      logic [63:0] w;
      clear_logs();
      lat = 1; ev_ready_en = 1'b0;
      start_frame(32'h0000_2000, 16'd20);
      for (int i = 0; i < 50; i++) cycle();
      n_checks++; if (addr_log.size() !== 8) begin n_fail++; $display("FAIL bp_req_count: got %0d want 8", addr_log.size()); end
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low: got %b want 0", bus.mem_req); end
      n_checks++; if (bus.ev_valid !== 1'b1) begin n_fail++; $display("FAIL bp_ev_valid: got %b want 1", bus.ev_valid); end
      ev_ready_en = 1'b1;
      for (int i = 0; i < 400 && done_cnt == 0; i++) cycle();
      for (int i = 0; i < 5; i++) cycle();
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d violations want 0", hold_viol); end
      n_checks++; if (ev_log.size() !== 20) begin n_fail++; $display("FAIL bp_event_count: got %0d want 20", ev_log.size()); end
      n_checks++; if (addr_log.size() !== 20) begin n_fail++; $display("FAIL bp_addr_count: got %0d want 20", addr_log.size()); end
      for (int i = 0; i < 20 && i < addr_log.size() && i < ev_log.size(); i++) begin
         a = 32'h0000_2000 + 32'(i * 8);
         w = mem_word(a);
         n_checks++; if (addr_log[i] !== a) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h want %h", i, addr_log[i], a); end
         n_checks++; if (ev_log[i] !== w[63:16]) begin n_fail++; $display("FAIL bp_event[%0d]: got %h want %h", i, ev_log[i], w[63:16]); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] a;
      logic [63:0] w;
      clear_logs();
      lat = 3; ready_toggle = 1'b1; rpat = 4'b1001; rp_idx = 0; ev_ready_en = 1'b1;
      start_frame(32'h0000_3000, 16'd20);
      for (int i = 0; i < 400 && done_cnt == 0; i++) cycle();
      for (int i = 0; i < 5; i++) cycle();
      ready_toggle = 1'b0; lat = 1;
      n_checks++; if (stall_cnt == 0) begin n_fail++; $display("FAIL stall_seen: got %0d stalls want >0", stall_cnt); end
      n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d violations want 0", stall_viol); end
      n_checks++; if (rvalid_cnt !== 20) begin n_fail++; $display("FAIL stall_received: got %0d want 20", rvalid_cnt); end
      n_checks++; if (ev_log.size() !== 20) begin n_fail++; $display("FAIL stall_event_count: got %0d want 20", ev_log.size()); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
      for (int i = 0; i < 20 && i < addr_log.size() && i < ev_log.size(); i++) begin
         a = 32'h0000_3000 + 32'(i * 8);
         w = mem_word(a);
         n_checks++; if (addr_log[i] !== a) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want %h", i, addr_log[i], a); end
         n_checks++; if (ev_log[i] !== w[63:16]) begin n_fail++; $display("FAIL stall_event[%0d]: got %h want %h", i, ev_log[i], w[63:16]); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] aexp [3];
      logic [47:0] eexp [3];
      clear_logs();
      lat = 1; ev_ready_en = 1'b1;
      aexp[0] = 32'hFFFF_FFF8; aexp[1] = 32'h0000_0000; aexp[2] = 32'h0000_0008;
      eexp[0] = 48'hFFFF_0000_FF5A; eexp[1] = 48'h0000_FFFF_00A5; eexp[2] = 48'h0001_FFFE_01A4;
      start_frame(32'hFFFF_FFF8, 16'd3);
      for (int i = 0; i < 40 && done_cnt == 0; i++) cycle();
      cycle();
      n_checks++; if (addr_log.size() !== 3) begin n_fail++; $display("FAIL wrap_addr_count: got %0d want 3", addr_log.size()); end
      n_checks++; if (ev_log.size() !== 3) begin n_fail++; $display("FAIL wrap_event_count: got %0d want 3", ev_log.size()); end
      for (int i = 0; i < 3 && i < addr_log.size() && i < ev_log.size(); i++) begin
         n_checks++; if (addr_log[i] !== aexp[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_log[i], aexp[i]); end
         n_checks++; if (ev_log[i] !== eexp[i]) begin n_fail++; $display("FAIL wrap_event[%0d]: got %h want %h", i, ev_log[i], eexp[i]); end
      end
   endtask

   task automatic test_overlap_reset();
      logic [31:0] a;
      logic [63:0] w;
      clear_logs();
      lat = 2; ev_ready_en = 1'b1;
      start_frame(32'h0000_4000, 16'd6);
      for (int i = 0; i < 3; i++) cycle();
      start_frame(32'h0000_9000, 16'd2);
      for (int i = 0; i < 60 && done_cnt == 0; i++) cycle();
      for (int i = 0; i < 6; i++) cycle();
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL overlap_done_count: got %0d want 1", done_cnt); end
      n_checks++; if (addr_log.size() !== 6) begin n_fail++; $display("FAIL overlap_addr_count: got %0d want 6", addr_log.size()); end
      n_checks++; if (ev_log.size() !== 6) begin n_fail++; $display("FAIL overlap_event_count: got %0d want 6", ev_log.size()); end
      n_checks++; if ((addr_log.size() > 0 ? addr_log[addr_log.size()-1] : 32'hX) !== 32'h0000_4028) begin n_fail++; $display("FAIL overlap_last_addr: got %h want 00004028", addr_log.size() > 0 ? addr_log[addr_log.size()-1] : 32'hX); end

      clear_logs();
      start_frame(32'h0000_5000, 16'd20);
      for (int i = 0; i < 4; i++) cycle();
      n_checks++; if ({busy, bus.mem_req} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_fetch: got %b want 11", {busy, bus.mem_req}); end
      #1 reset = 1'b1;
      pend.delete();
      bus.mem_rvalid = 1'b0;
      prev_stall = 1'b0; prev_hold = 1'b0;
      #1;
      n_checks++; if ({bus.mem_req, bus.ev_valid, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL rst_async_outputs: got %b want 0000", {bus.mem_req, bus.ev_valid, busy, done}); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_async_addr: got %h want 0", bus.mem_addr); end
      cycle(); cycle();
      reset = 1'b0;
      cycle();
      clear_logs();
      lat = 1;
      start_frame(32'h0000_6000, 16'd4);
      for (int i = 0; i < 60 && done_cnt == 0; i++) cycle();
      cycle(); cycle();
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rst_new_done_count: got %0d want 1", done_cnt); end
      n_checks++; if (ev_log.size() !== 4) begin n_fail++; $display("FAIL rst_new_event_count: got %0d want 4", ev_log.size()); end
      for (int i = 0; i < 4 && i < addr_log.size() && i < ev_log.size(); i++) begin
         a = 32'h0000_6000 + 32'(i * 8);
         w = mem_word(a);
         n_checks++; if (addr_log[i] !== a) begin n_fail++; $display("FAIL rst_new_addr[%0d]: got %h want %h", i, addr_log[i], a); end
         n_checks++; if (ev_log[i] !== w[63:16]) begin n_fail++; $display("FAIL rst_new_event[%0d]: got %h want %h", i, ev_log[i], w[63:16]); end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; lat = 1; fs_cyc = 0; rp_idx = 0;
      ready_toggle = 1'b0; ev_ready_en = 1'b0; fs_req = 1'b0;
      prev_stall = 1'b0; prev_hold = 1'b0; rpat = 4'b1111;
      prev_addr = '0; prev_fields = '0;
      reset = 1'b0; frame_start = 1'b0; buffer_base = '0; event_count = '0;
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.ev_ready = 1'b0;
      clear_logs();
      test_reset();
      test_single();
      test_zero_count();
      test_backpressure();
      test_stall();
      test_wrap();
      test_overlap_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
